// File: rtl/cursor_measure_unit.sv
// rtl/cursor_measure_unit.sv - cursor delta measurement with per-channel scaling and saturation
module cursor_measure_unit #(
  parameter int CHANNELS = 2,
  parameter int CUR_W    = 11,
  parameter int SHIFT_W  = 4,
  parameter int RATE_W   = 6,
  parameter int OUT_W    = 14
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CUR_W-1:0]             cursorx1,
  input  logic [CUR_W-1:0]             cursorx2,
  input  logic [CUR_W-1:0]             cursory1,
  input  logic [CUR_W-1:0]             cursory2,
  input  logic [CHANNELS*SHIFT_W-1:0]  shiftDown,
  input  logic [CHANNELS*RATE_W-1:0]   sampleadjust,
  input  logic [1:0]                   waveSel,
  input  logic [2:0]                   measurement,
  output logic [OUT_W-1:0]             num,
  output logic                         valid,
  output logic                         busy,
  output logic                         overflow,
  output logic                         sel_err
);

  localparam int PW = OUT_W + 8;
  localparam logic [PW-1:0] MAXV = {{8{1'b0}}, {OUT_W{1'b1}}};
  localparam logic [2:0] CH = 3'(CHANNELS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    DIFF    = 3'd2,
    SCALE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, stateNext;

  logic [CUR_W-1:0]   x1q, x2q, y1q, y2q, dx, dy;
  logic [SHIFT_W-1:0] shiftSel, shiftQ;
  logic [RATE_W-1:0]  rateSel, rateQ;
  logic [2:0]         modeQ;
  logic               selErrIn, selErrQ;
  logic [PW-1:0]      dxW, dyW, shiftW, rateW, prod;
  logic               ovNext;
  logic [OUT_W-1:0]   numNext;

  // Out-of-range channel selects fall through with zero scale and raise sel_err.
  always_comb begin
    shiftSel = '0;
    rateSel  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (waveSel == 2'(c)) begin
        shiftSel = shiftDown[c*SHIFT_W +: SHIFT_W];
        rateSel  = sampleadjust[c*RATE_W +: RATE_W];
      end
    end
    selErrIn = ({1'b0, waveSel} >= CH);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CAPTURE;
      CAPTURE: stateNext = DIFF;
      DIFF:    stateNext = SCALE;
      SCALE:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign dxW    = PW'(dx);
  assign dyW    = PW'(dy);
  assign shiftW = PW'(shiftQ) + PW'(1);
  assign rateW  = PW'(rateQ) + PW'(1);

  always_comb begin
    prod = '0;
    if (!selErrQ) begin
      case (modeQ)
        3'd1:    prod = dxW;
        3'd2:    prod = dyW * shiftW;
        3'd3:    prod = (dyW * shiftW) << 1;
        3'd4:    prod = dxW * rateW;
        default: prod = '0;
      endcase
    end
    ovNext  = (prod > MAXV);
    numNext = ovNext ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
  end

  // Operands are latched on the accepting edge so later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      x1q      <= '0;
      x2q      <= '0;
      y1q      <= '0;
      y2q      <= '0;
      dx       <= '0;
      dy       <= '0;
      shiftQ   <= '0;
      rateQ    <= '0;
      modeQ    <= '0;
      selErrQ  <= 1'b0;
      num      <= '0;
      overflow <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        x1q     <= cursorx1;
        x2q     <= cursorx2;
        y1q     <= cursory1;
        y2q     <= cursory2;
        shiftQ  <= shiftSel;
        rateQ   <= rateSel;
        modeQ   <= measurement;
        selErrQ <= selErrIn;
      end
      if (state == CAPTURE) begin
        dx <= (x1q >= x2q) ? (x1q - x2q) : (x2q - x1q);
        dy <= (y1q >= y2q) ? (y1q - y2q) : (y2q - y1q);
      end
      if (state == SCALE) begin
        num      <= numNext;
        overflow <= ovNext;
        sel_err  <= selErrQ;
      end
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state == CAPTURE) || (state == DIFF) || (state == SCALE);

endmodule

// File: tb/tb_cursor_measure_unit.sv
// tb/tb_cursor_measure_unit.sv - randomized scoreboard bench for cursor_measure_unit
module tb_cursor_measure_unit;

  localparam int CHANNELS = 2;
  localparam int CUR_W    = 11;
  localparam int SHIFT_W  = 4;
  localparam int RATE_W   = 6;
  localparam int OUT_W    = 14;
  localparam int MAXV     = (1 << OUT_W) - 1;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        start = 1'b0;
  logic [CUR_W-1:0]            cursorx1 = '0, cursorx2 = '0, cursory1 = '0, cursory2 = '0;
  logic [CHANNELS*SHIFT_W-1:0] shiftDown = '0;
  logic [CHANNELS*RATE_W-1:0]  sampleadjust = '0;
  logic [1:0]                  waveSel = '0;
  logic [2:0]                  measurement = '0;
  logic [OUT_W-1:0]            num;
  logic                        valid, busy, overflow, sel_err;

  cursor_measure_unit #(
    .CHANNELS(CHANNELS), .CUR_W(CUR_W), .SHIFT_W(SHIFT_W), .RATE_W(RATE_W), .OUT_W(OUT_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cursorx1(cursorx1), .cursorx2(cursorx2), .cursory1(cursory1), .cursory2(cursory2),
    .shiftDown(shiftDown), .sampleadjust(sampleadjust), .waveSel(waveSel),
    .measurement(measurement), .num(num), .valid(valid), .busy(busy),
    .overflow(overflow), .sel_err(sel_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int num;
    int ov;
    int se;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   lastAcc = -100;
  int   nChecks = 0;
  int   nFail = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: absolute deltas, selected channel scale, clamp to OUT_W bits.
  function automatic exp_t model(input int x1, input int x2, input int y1, input int y2,
                                 input int sd, input int sa, input int ws, input int m,
                                 input int c);
    exp_t e;
    longint dxv, dyv, p;
    int sh, rt;
    dxv = (x1 > x2) ? x1 - x2 : x2 - x1;
    dyv = (y1 > y2) ? y1 - y2 : y2 - y1;
    e.cyc = c + 4;
    if (ws >= CHANNELS) begin
      e.num = 0; e.ov = 0; e.se = 1;
      return e;
    end
    sh = (sd >> (ws * SHIFT_W)) & ((1 << SHIFT_W) - 1);
    rt = (sa >> (ws * RATE_W)) & ((1 << RATE_W) - 1);
    case (m)
      1:       p = dxv;
      2:       p = dyv * (sh + 1);
      3:       p = 2 * dyv * (sh + 1);
      4:       p = dxv * (rt + 1);
      default: p = 0;
    endcase
    e.se  = 0;
    e.ov  = (p > MAXV) ? 1 : 0;
    e.num = (p > MAXV) ? MAXV : int'(p);
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("valid_latency", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      chk("valid", int'(valid), (q.size() > 0 && q[0].cyc == cyc) ? 1 : 0);
      chk("busy", int'(busy), (cyc >= lastAcc + 1 && cyc <= lastAcc + 3) ? 1 : 0);
      if (valid && q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("num", int'(num), e.num);
        chk("overflow", int'(overflow), e.ov);
        chk("sel_err", int'(sel_err), e.se);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input int x1, input int x2, input int y1, input int y2,
                       input int sd, input int sa, input int ws, input int m);
    @(posedge clock); #1;
    cursorx1 = CUR_W'(x1); cursorx2 = CUR_W'(x2);
    cursory1 = CUR_W'(y1); cursory2 = CUR_W'(y2);
    shiftDown = (CHANNELS*SHIFT_W)'(sd);
    sampleadjust = (CHANNELS*RATE_W)'(sa);
    waveSel = 2'(ws);
    measurement = 3'(m);
    start = 1'b1;
    if (cyc >= lastAcc + 5) begin
      q.push_back(model(x1, x2, y1, y2, sd, sa, ws, m, cyc));
      lastAcc = cyc;
    end
    @(posedge clock); #1;
    start = 1'b0;
    cursorx1 = CUR_W'($urandom); cursorx2 = CUR_W'($urandom);
    cursory1 = CUR_W'($urandom); cursory2 = CUR_W'($urandom);
    shiftDown = (CHANNELS*SHIFT_W)'($urandom);
    sampleadjust = (CHANNELS*RATE_W)'($urandom);
    waveSel = 2'($urandom);
    measurement = 3'($urandom);
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_num"}, int'(num), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_sel_err"}, int'(sel_err), 0);
  endtask

  initial begin
    int waited;
    idle(3);
    reset = 1'b0;
    check_idle_state("reset");

    issue(0, 0, 300, 100, 3, 0, 0, 3);        idle(5);
    issue(0, 0, 100, 300, 3, 0, 0, 3);        idle(5);
    issue(700, 700, 5, 9, 0, 0, 0, 1);        idle(5);
    issue(0, 0, 2000, 0, 15, 0, 0, 3);        idle(5);
    issue(0, 0, 10, 0, 15, 0, 0, 3);          idle(5);
    issue(50, 20, 0, 0, 0, 12'h240, 1, 4);    idle(5);
    issue(10, 0, 0, 0, 0, 0, 0, 1);           idle(1);
    issue(99, 0, 0, 0, 0, 0, 0, 1);           idle(6);
    issue(2047, 0, 2047, 0, 8'hFF, 12'hFFF, 0, 4); idle(5);
    issue(30, 10, 0, 0, 0, 0, 3, 1);          idle(5);
    issue(30, 10, 40, 0, 0, 0, 0, 6);         idle(5);

    // Reset two cycles after an accepted start must abort without a valid.
    issue(300, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    reset = 1'b1;
    q.delete();
    lastAcc = -100;
    idle(1);
    reset = 1'b0;
    check_idle_state("abort");
    idle(8);
    chk("abort_num", int'(num), 0);

    // Back-to-back and overlapping starts; some are ignored while busy.
    repeat (150) begin
      issue($urandom_range(0, 2047), $urandom_range(0, 2047),
            $urandom_range(0, 2047), $urandom_range(0, 2047),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)),
            $urandom_range(0, 3), $urandom_range(0, 7));
      idle($urandom_range(0, 6));
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      idle(1);
      waited++;
    end
    chk("drain_pending", q.size(), 0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
